// File: rtl/mem_responder_if.sv
// Bus bundle for the single-port memory responder: request side driven by the
// master (driver), response/status side driven by the slave (responder).
interface mem_responder_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 16,
    parameter int CNT_W  = 8
);
    logic              wr_en;
    logic              rd_en;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              rvalid;
    logic              rd_uninit;
    logic              collision;
    logic [CNT_W-1:0]  wr_count;
    logic [CNT_W-1:0]  rd_count;

    modport master (
        output wr_en, rd_en, addr, wdata,
        input  rdata, rvalid, rd_uninit, collision, wr_count, rd_count
    );

    modport slave (
        input  wr_en, rd_en, addr, wdata,
        output rdata, rvalid, rd_uninit, collision, wr_count, rd_count
    );
endinterface

// File: rtl/mem_responder.sv
// Single-port memory responder: 1-cycle registered read-first RAM with
// written-since-reset tracking, collision strobe and saturating access counters.
module mem_responder #(
    parameter int                 ADDR_W     = 4,
    parameter int                 DATA_W     = 16,
    parameter int                 CNT_W      = 8,
    parameter logic [DATA_W-1:0]  UNINIT_VAL = 16'hDEAD
) (
    input  logic            clk,
    input  logic            reset,
    mem_responder_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  wvalid_reg;

    logic [DATA_W-1:0] rdata_reg;
    logic              rvalid_reg;
    logic              rd_uninit_reg;
    logic              collision_reg;
    logic [CNT_W-1:0]  wr_count_reg;
    logic [CNT_W-1:0]  rd_count_reg;

    logic wr_ok;
    logic rd_ok;

    // Requests in a reset cycle are discarded entirely.
    assign wr_ok = bus.wr_en && !reset;
    assign rd_ok = bus.rd_en && !reset;

    // Contents are deliberately not cleared; wvalid_reg hides stale data.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[bus.addr] <= bus.wdata;
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wvalid
            always_ff @(posedge clk) begin
                if (reset) begin
                    wvalid_reg[gi] <= 1'b0;
                end else if (bus.wr_en && (bus.addr == ADDR_W'(gi))) begin
                    wvalid_reg[gi] <= 1'b1;
                end
            end
        end
    endgenerate

    // Read-first: mem and wvalid_reg are sampled before this edge's write lands.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_reg     <= '0;
            rvalid_reg    <= 1'b0;
            rd_uninit_reg <= 1'b0;
            collision_reg <= 1'b0;
        end else begin
            rvalid_reg    <= bus.rd_en;
            rd_uninit_reg <= bus.rd_en && !wvalid_reg[bus.addr];
            collision_reg <= bus.rd_en && bus.wr_en;
            if (bus.rd_en) begin
                rdata_reg <= wvalid_reg[bus.addr] ? mem[bus.addr] : UNINIT_VAL;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_count_reg <= '0;
            rd_count_reg <= '0;
        end else begin
            if (wr_ok && !(&wr_count_reg)) begin
                wr_count_reg <= wr_count_reg + CNT_W'(1);
            end
            if (rd_ok && !(&rd_count_reg)) begin
                rd_count_reg <= rd_count_reg + CNT_W'(1);
            end
        end
    end

    assign bus.rdata     = rdata_reg;
    assign bus.rvalid    = rvalid_reg;
    assign bus.rd_uninit = rd_uninit_reg;
    assign bus.collision = collision_reg;
    assign bus.wr_count  = wr_count_reg;
    assign bus.rd_count  = rd_count_reg;
endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the single-port read/write protocol: the 16-entry × 16-bit storage target that the testbench driver's `wr_en`/`rd_en`/`addr`/`wdata` stimulus acts on, returning `rdata`. It adds:
- a one-cycle registered read with a `rvalid` strobe;
- per-entry "written since reset" tracking with an uninitialised-read flag;
- a simultaneous-access flag;
- saturating access counters for scoreboard cross-checks.

## Interface
Parameters:
- `ADDR_W`, default 4: address width; depth is 2**ADDR_W.
- `DATA_W`, default 16: data width.
- `CNT_W`, default 8: access counter width.
- `UNINIT_VAL`, default 16'hDEAD (DATA_W bits): data returned for reads of unwritten entries.

Ports:
- `clk`  in  1  single clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `wr_en`  in  1  write request, sampled at posedge.
- `rd_en`  in  1  read request, sampled at posedge.
- `addr`  in  ADDR_W  entry address for read and/or write.
- `wdata`  in  DATA_W  write data.
- `rdata`  out  DATA_W  registered read data.
- `rvalid`  out  1  one-cycle strobe: `rdata` holds the result of the previous cycle's read.
- `rd_uninit`  out  1  strobe aligned with `rvalid`: that read hit an unwritten entry.
- `collision`  out  1  strobe: previous cycle had `rd_en` and `wr_en` both high.
- `wr_count`  out  CNT_W  accepted writes since reset; saturating.
- `rd_count`  out  CNT_W  accepted reads since reset; saturating.

## Operation
- **Storage:** `mem[0:2**ADDR_W-1]` of DATA_W bits, plus a valid vector `wvalid[0:2**ADDR_W-1]`.
- **Reset contents:** `mem` is not cleared; `wvalid` is cleared to all zeros.
- **Write** (`wr_en`=1, not in reset): `mem[addr]` <= `wdata`; `wvalid[addr]` <= 1; `wr_count` increments unless at all-ones.
- **Read** (`rd_en`=1, not in reset):
  - `rvalid` <= 1; `rd_count` increments unless at all-ones.
  - If `wvalid[addr]`=1: `rdata` <= `mem[addr]` and `rd_uninit` <= 0.
  - Otherwise: `rdata` <= `UNINIT_VAL` and `rd_uninit` <= 1.
- **No read:** `rvalid` <= 0 and `rd_uninit` <= 0; `rdata` holds its last value.
- **Simultaneous read and write** (same or different address): both are performed and `collision` <= 1 for one cycle.
  - Read-first semantics: on a same-address collision, `rdata` returns the pre-write content, or `UNINIT_VAL` with `rd_uninit`=1 if the entry was unwritten before this cycle.
  - Both counters increment.
- **Addressing:** `addr` is always in range, so there is no wrap or decode error. Counters saturate and never wrap.
- **Reset values:** `rdata`=0, `rvalid`=0, `rd_uninit`=0, `collision`=0, `wr_count`=0, `rd_count`=0.
- **Reset priority:** `reset` overrides everything. Any `wr_en`/`rd_en` in a reset cycle is discarded, with no memory update, no strobes and no count.

## Timing
- Write latency: `mem` is updated at the posedge that samples `wr_en`. A read of the same address in the next cycle returns the new data.
- Read latency: exactly 1 cycle. `rd_en` sampled at edge N gives `rdata`/`rvalid`/`rd_uninit` valid from N until edge N+1.
- Back-to-back reads every cycle: `rvalid` stays high continuously, with a new `rdata` each cycle.
- `collision` is asserted in the same cycle as the `rvalid` for the colliding read.
- Reset asserted mid-stream: at the reset edge all outputs go to their reset values, and a read sampled at that edge yields no `rvalid`. The first access is accepted at the first edge with `reset`=0.
- No combinational path from inputs to outputs.

## Test plan
- **Reset then read:** reset; read addr 3 -> next cycle `rdata`=16'hDEAD, `rvalid`=1, `rd_uninit`=1, `rd_count`=1, `wr_count`=0.
- **Write then read back:** write 16'h1234 to addr 5; next cycle read addr 5 -> `rdata`=16'h1234, `rd_uninit`=0; `wr_count`=1, `rd_count`=1.
- **Same-address collision:** write 16'hAAAA to addr 7, then `wr_en`+`rd_en` at addr 7 with `wdata`=16'h5555 -> `rdata`=16'hAAAA, `collision`=1. A following read of addr 7 returns 16'h5555 with `collision`=0.
- **Back-to-back reads:** fill addrs 0..15 with `addr`×16'h0101; read 0..15 on consecutive cycles -> `rvalid` high for 16 consecutive cycles with matching data.
- **Counter saturation:** 300 writes -> `wr_count` holds 8'hFF; `rd_count` unchanged.
- **Reset mid-stream:** write addr 2 = 16'hBEEF; assert `reset` during a read of addr 2 -> no `rvalid`, counters 0. After reset, read addr 2 -> 16'hDEAD with `rd_uninit`=1, because `wvalid` was cleared.
